// File: rtl/rc4_pkg.sv
// Shared types and character constants for the decrypted-message checker.
package rc4_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetAddr,
    StWaitRd,
    StCheck,
    StDone
  } state_e;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_A     = 8'h61;
  localparam logic [7:0] CHAR_Z     = 8'h7A;

endpackage

// File: rtl/message_checker_if.sv
// Start/RAM-read/result bundle between the message checker and its environment.
interface message_checker_if;

  logic       start;
  logic [7:0] q_ram;
  logic [7:0] address_ram;
  logic       busy;
  logic       finish;
  logic       valid;
  logic [7:0] bad_index;
  logic [8:0] bad_count;

  modport master (
    output start, q_ram,
    input  address_ram, busy, finish, valid, bad_index, bad_count
  );

  modport slave (
    input  start, q_ram,
    output address_ram, busy, finish, valid, bad_index, bad_count
  );

endinterface

// File: rtl/msg_char_classifier.sv
// Combinational legality test: lowercase 'a'..'z' or space.
module msg_char_classifier
  import rc4_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_legal
);

  assign o_legal = ((i_char >= CHAR_A) && (i_char <= CHAR_Z)) || (i_char == CHAR_SPACE);

endmodule

// File: rtl/message_checker.sv
// Scans MSG_LEN bytes of the decrypted-message RAM and reports legality statistics.
// Define CHECK_EARLY_EXIT_EN to stop at the first illegal byte.
module message_checker
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN   = 32,
  parameter logic [7:0]  BASE_ADDR = 8'h00
) (
  input logic              clk,
  input logic              reset,
  message_checker_if.slave bus
);

  localparam logic [7:0] LastK = 8'(MSG_LEN - 1);

  state_e     r_state, w_state_next;
  logic [7:0] r_k, w_k_next;
  logic [7:0] r_address, w_address_next;
  logic [7:0] r_bad_index, w_bad_index_next;
  logic [8:0] r_bad_count, w_bad_count_next;
  logic       r_valid, w_valid_next;
  logic       w_legal;
  logic       w_last;

  msg_char_classifier u_classifier (
    .i_char  (bus.q_ram),
    .o_legal (w_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_k         <= '0;
      r_address   <= '0;
      r_bad_index <= '0;
      r_bad_count <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_k         <= w_k_next;
      r_address   <= w_address_next;
      r_bad_index <= w_bad_index_next;
      r_bad_count <= w_bad_count_next;
      r_valid     <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_k_next         = r_k;
    w_address_next   = r_address;
    w_bad_index_next = r_bad_index;
    w_bad_count_next = r_bad_count;
    w_valid_next     = r_valid;
    w_last           = (r_k == LastK);

    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_next     = StSetAddr;
          w_k_next         = '0;
          w_bad_index_next = '0;
          w_bad_count_next = '0;
          w_valid_next     = 1'b0;
        end
      end
      StSetAddr: w_state_next = StWaitRd;
      // RAM data for the issued address arrives two cycles later, in StCheck.
      StWaitRd:  w_state_next = StCheck;
      StCheck: begin
        if (!w_legal) begin
          if (r_bad_count == '0) w_bad_index_next = r_k;
          w_bad_count_next = r_bad_count + 9'd1;
        end
`ifdef CHECK_EARLY_EXIT_EN
        if (w_last || !w_legal) begin
`else
        if (w_last) begin
`endif
          w_state_next = StDone;
          w_valid_next = (w_bad_count_next == '0);
        end else begin
          w_k_next     = r_k + 8'd1;
          w_state_next = StSetAddr;
        end
      end
      StDone: begin
        if (!bus.start) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase

    // Address is presented for the whole SET_ADDR/WAIT_RD/CHECK span; 8-bit add wraps.
    if (w_state_next == StSetAddr) w_address_next = BASE_ADDR + w_k_next;
  end

  assign bus.address_ram = r_address;
  assign bus.busy        = (r_state == StSetAddr) || (r_state == StWaitRd) ||
                           (r_state == StCheck);
  assign bus.finish      = (r_state == StDone);
  assign bus.valid       = r_valid;
  assign bus.bad_index   = r_bad_index;
  assign bus.bad_count   = r_bad_count;

endmodule
